// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the decimal digit entry block.
package digit_entry_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BKSP = 1'b1
    } state_t;

    localparam int TEN         = 10;
    localparam int MAX_MAG_DEF = 255;
    localparam int DIV_CYCLES  = 8;
    // 10*255 + 9 = 2559 needs 12 bits
    localparam int CAND_W      = 12;

endpackage

// File: rtl/digit_entry_div10_seq.sv
// Sequential restoring divide-by-10 of an 8-bit value, one quotient bit per cycle.
module div10_seq
    import digit_entry_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] dividend,
    output logic [7:0] quotient,
    output logic       done
);

    logic [2:0] cnt;
    logic [3:0] rem;
    logic [7:0] sh;
    logic       running;
    logic [4:0] trial;
    logic       ge;
    logic [3:0] rem_next;

    always_comb begin
        trial    = {rem, sh[7]};
        ge       = (trial >= 5'(TEN));
        rem_next = ge ? 4'(trial - 5'(TEN)) : trial[3:0];
        // Final quotient bit is folded in combinationally so the caller can
        // capture the result on the terminal-count cycle itself.
        quotient = {sh[6:0], ge};
        done     = running && (cnt == 3'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            rem     <= '0;
            sh      <= '0;
            running <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
        end else if (start) begin
            sh      <= dividend;
            rem     <= '0;
            cnt     <= 3'(DIV_CYCLES - 1);
            running <= 1'b1;
        end else if (running) begin
            sh  <= {sh[6:0], ge};
            rem <= rem_next;
            cnt <= cnt - 3'd1;
            if (cnt == 3'd0)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/digit_entry.sv
// Builds a signed-magnitude value from decimal key presses; commit on enter.
//  state | meaning
//  IDLE  | accepts clear/enter/backspace/digit/neg_toggle in that priority
//  BKSP  | divider running; only clear is honoured (aborts the divide)
module digit_entry
    import digit_entry_pkg::*;
#(
    parameter int MAX_MAG = MAX_MAG_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       neg_toggle,
    input  logic       backspace,
    input  logic       clear,
    input  logic       enter,
    output logic [7:0] edit_mag,
    output logic       edit_neg,
    output logic [7:0] out_mag,
    output logic       out_neg,
    output logic       out_valid,
    output logic       busy,
    output logic       overflow
);

    state_t              state;
    logic [CAND_W-1:0]   cand;
    logic                div_start;
    logic                div_abort;
    logic [7:0]          div_q;
    logic                div_done;

    always_comb begin
        cand      = CAND_W'(edit_mag) * CAND_W'(TEN) + CAND_W'(digit);
        div_start = (state == IDLE) && backspace && !clear && !enter;
        div_abort = (state == BKSP) && clear;
    end

    div10_seq u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (edit_mag),
        .quotient (div_q),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            edit_mag  <= '0;
            edit_neg  <= 1'b0;
            out_mag   <= '0;
            out_neg   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        edit_mag <= '0;
                        edit_neg <= 1'b0;
                    end else if (enter) begin
                        out_mag   <= edit_mag;
                        out_neg   <= edit_neg;
                        out_valid <= 1'b1;
                        edit_mag  <= '0;
                        edit_neg  <= 1'b0;
                    end else if (backspace) begin
                        state <= BKSP;
                        busy  <= 1'b1;
                    end else if (digit_valid) begin
                        if (digit < 4'(TEN)) begin
                            if (cand <= CAND_W'(MAX_MAG))
                                edit_mag <= cand[7:0];
                            else
                                overflow <= 1'b1;
                        end
                    end else if (neg_toggle) begin
                        edit_neg <= ~edit_neg;
                    end
                end
                BKSP: begin
                    if (clear) begin
                        edit_mag <= '0;
                        edit_neg <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (div_done) begin
                        edit_mag <= div_q;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
